// File: rtl/sram_port0_req_ctrl.sv
// sram_port0_req_ctrl: valid/ready request front-end for OpenRAM 1rw1r port 0 with a credit-counted read FIFO.
// Define SRAM_CTRL_INIT_EN to zero-fill the whole macro after reset before requests are accepted.
module sram_port0_req_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WMASKS = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 3);

    logic                  p1, p2, accept, pop;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count, credits;
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] last;

    // Reads in flight hold a FIFO slot so the response can never overflow.
    assign credits   = CW'(p1) + CW'(p2) + count;
    assign req_ready = init_done && credits < CW'(RSP_DEPTH);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = count != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? mem[rd_ptr] : last;

`ifdef SRAM_CTRL_INIT_EN
    localparam int IW = ADDR_WIDTH + 1;
    typedef enum logic {INIT, RUN} state_t;
    state_t        state;
    logic [IW-1:0] init_cnt;
`else
    assign init_done = 1'b1;
`endif

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
`ifdef SRAM_CTRL_INIT_EN
            state     <= INIT;
            init_done <= 1'b0;
            init_cnt  <= '0;
`endif
        end
`ifdef SRAM_CTRL_INIT_EN
        else if (state == INIT) begin
            csb0 <= init_cnt[ADDR_WIDTH];
            web0 <= init_cnt[ADDR_WIDTH];
            if (init_cnt[ADDR_WIDTH]) begin
                state     <= RUN;
                init_done <= 1'b1;
            end else begin
                wmask0   <= '1;
                din0     <= '0;
                addr0    <= init_cnt[ADDR_WIDTH-1:0];
                init_cnt <= init_cnt + IW'(1);
            end
        end
`endif
        else begin
            csb0 <= !accept;
            web0 <= !(accept && req_we);
            if (accept) begin
                addr0  <= req_addr;
                din0   <= req_wdata;
                wmask0 <= req_wmask;
            end
        end
    end

    // dout0 is only valid one full cycle after the macro samples a read.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            p1     <= 1'b0;
            p2     <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            last   <= '0;
        end else begin
            p1    <= accept && !req_we;
            p2    <= p1;
            count <= count + CW'(p2) - CW'(pop);
            if (p2)
                wr_ptr <= wr_ptr == PW'(RSP_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr == PW'(RSP_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
                last   <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk0)
        if (p2)
            mem[wr_ptr] <= dout0;

endmodule
